decode_stage: RTL

- Pipelined RV32I instruction decode stage, directly downstream of the fetch unit; feeds the control/execute path.
- Accepts a raw 32-bit instruction word plus its PC over a valid/ready handshake.
- Registers the instruction and cracks it into op class, register indices, funct fields and a sign-extended immediate.
- Contains a 2-entry skid buffer so that downstream backpressure never drops or duplicates an instruction.

---
 rtl/riscv_pkg.sv | 53 +++++
 rtl/decode_comb.sv | 113 +++++++++++
 rtl/decode_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: op-class enum, opcode/funct7 constants and the stored bundle.
package riscv_pkg;

  typedef enum logic [3:0] {
    OP_NONE    = 4'd0,
    OP_ALU_R   = 4'd1,
    OP_ALU_I   = 4'd2,
    OP_LOAD    = 4'd3,
    OP_STORE   = 4'd4,
    OP_BRANCH  = 4'd5,
    OP_JAL     = 4'd6,
    OP_JALR    = 4'd7,
    OP_LUI     = 4'd8,
    OP_AUIPC   = 4'd9,
    OP_SYSTEM  = 4'd10,
    OP_FENCE   = 4'd11,
    OP_MULDIV  = 4'd12,
    OP_ILLEGAL = 4'd15
  } op_class_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    op_class_e   op_class;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        illegal;
  } bundle_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I field/immediate/legality cracker.
// DECODE_MULDIV_EN: when defined, OP with funct7=0000001 decodes as MULDIV instead of ILLEGAL.
module decode_comb
  import riscv_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [3:0]  op_class_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o,
  output logic [31:0] imm_o,
  output logic        illegal_o
);

`ifdef DECODE_MULDIV_EN
  localparam op_class_e MULDIV_CLASS = OP_MULDIV;
`else
  localparam op_class_e MULDIV_CLASS = OP_ILLEGAL;
`endif

  logic [6:0]  f7_s;
  logic [2:0]  f3_s;
  op_class_e   cls_s;
  logic [31:0] imm_s;

  assign f7_s       = inst_i[31:25];
  assign f3_s       = inst_i[14:12];
  assign rd_o       = inst_i[11:7];
  assign rs1_o      = inst_i[19:15];
  assign rs2_o      = inst_i[24:20];
  assign funct3_o   = f3_s;
  assign funct7b5_o = inst_i[30];
  assign op_class_o = cls_s;
  assign illegal_o  = (cls_s == OP_ILLEGAL);
  assign imm_o      = (cls_s == OP_ILLEGAL) ? 32'd0 : imm_s;

  // Opcode classification, funct7 legality and immediate format selection.
  always_comb begin
    cls_s = OP_ILLEGAL;
    imm_s = 32'd0;
    if (inst_i[1:0] != 2'b11) begin
      cls_s = OP_ILLEGAL;
    end else begin
      case (inst_i[6:0])
        OPC_OP: begin
          if (f7_s == F7_ZERO) begin
            cls_s = OP_ALU_R;
          end else if (f7_s == F7_ALT && (f3_s == 3'b000 || f3_s == 3'b101)) begin
            cls_s = OP_ALU_R;
          end else if (f7_s == F7_MULDIV) begin
            cls_s = MULDIV_CLASS;
          end else begin
            cls_s = OP_ILLEGAL;
          end
        end
        OPC_OP_IMM: begin
          imm_s = sext12(inst_i[31:20]);
          // Shift-immediates reuse imm[11:5] as funct7: SLLI needs 0, SRLI/SRAI 0 or 0x20.
          if (f3_s == 3'b001 && f7_s != F7_ZERO) begin
            cls_s = OP_ILLEGAL;
          end else if (f3_s == 3'b101 && f7_s != F7_ZERO && f7_s != F7_ALT) begin
            cls_s = OP_ILLEGAL;
          end else begin
            cls_s = OP_ALU_I;
          end
        end
        OPC_LOAD: begin
          cls_s = OP_LOAD;
          imm_s = sext12(inst_i[31:20]);
        end
        OPC_STORE: begin
          cls_s = OP_STORE;
          imm_s = sext12({inst_i[31:25], inst_i[11:7]});
        end
        OPC_BRANCH: begin
          cls_s = OP_BRANCH;
          imm_s = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        end
        OPC_JAL: begin
          cls_s = OP_JAL;
          imm_s = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        end
        OPC_JALR: begin
          cls_s = OP_JALR;
          imm_s = sext12(inst_i[31:20]);
        end
        OPC_LUI: begin
          cls_s = OP_LUI;
          imm_s = {inst_i[31:12], 12'd0};
        end
        OPC_AUIPC: begin
          cls_s = OP_AUIPC;
          imm_s = {inst_i[31:12], 12'd0};
        end
        OPC_SYSTEM: begin
          cls_s = OP_SYSTEM;
          imm_s = sext12(inst_i[31:20]);
        end
        OPC_FENCE: begin
          cls_s = OP_FENCE;
          imm_s = sext12(inst_i[31:20]);
        end
        default: begin
          cls_s = OP_ILLEGAL;
          imm_s = 32'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes inst_i, then buffers bundles in an OUT + SKID pair (strict FIFO).
// DECODE_MULDIV_EN (see decode_comb) enables MULDIV decoding.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit FLUSH_KEEPS_SKID = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        inst_valid_i,
  output logic        inst_ready_o,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [3:0]  op_class_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o,
  output logic [31:0] imm_o,
  output logic [31:0] pc_o,
  output logic        illegal_o
);

  if (XLEN != 32) begin : g_xlen_check
    $error("decode_stage supports only XLEN=32");
  end

  logic [3:0]  cls_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [2:0]  f3_s;
  logic        f7b5_s, ill_s;
  logic [31:0] imm_s;
  bundle_t     dec_s;

  bundle_t out_q, out_d, skid_q, skid_d;
  logic    out_v_q, out_v_d, skid_v_q, skid_v_d, ready_q, ready_d;
  logic    in_accept_s, out_drain_s;

  decode_comb u_decode_comb (
    .inst_i     (inst_i),
    .op_class_o (cls_s),
    .rd_o       (rd_s),
    .rs1_o      (rs1_s),
    .rs2_o      (rs2_s),
    .funct3_o   (f3_s),
    .funct7b5_o (f7b5_s),
    .imm_o      (imm_s),
    .illegal_o  (ill_s)
  );

  assign in_accept_s = inst_valid_i & ready_q;
  assign out_drain_s = out_v_q & out_ready_i;

  // Pack the freshly decoded instruction with its PC.
  always_comb begin
    dec_s          = '0;
    dec_s.op_class = op_class_e'(cls_s);
    dec_s.rd       = rd_s;
    dec_s.rs1      = rs1_s;
    dec_s.rs2      = rs2_s;
    dec_s.funct3   = f3_s;
    dec_s.funct7b5 = f7b5_s;
    dec_s.imm      = imm_s;
    dec_s.pc       = pc_i;
    dec_s.illegal  = ill_s;
  end

  // Next-state for the OUT/SKID pair; flush overrides any accept or drain.
  always_comb begin
    out_d    = out_q;
    skid_d   = skid_q;
    out_v_d  = out_v_q;
    skid_v_d = skid_v_q;
    if (flush_i) begin
      out_v_d = 1'b0;
      if (FLUSH_KEEPS_SKID) begin
        skid_v_d = skid_v_q;
      end else begin
        skid_v_d = 1'b0;
      end
    end else if (skid_v_q) begin
      // Ready is low while SKID is occupied, so only a promotion can happen here.
      if (out_drain_s || !out_v_q) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        out_v_d = out_v_q;
      end
    end else if (out_drain_s || !out_v_q) begin
      if (in_accept_s) begin
        out_d   = dec_s;
        out_v_d = 1'b1;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (in_accept_s) begin
      skid_d   = dec_s;
      skid_v_d = 1'b1;
    end else begin
      skid_v_d = skid_v_q;
    end
    ready_d = ~skid_v_d;
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q    <= '0;
      skid_q   <= '0;
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      out_q    <= out_d;
      skid_q   <= skid_d;
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
      ready_q  <= ready_d;
    end
  end

  assign inst_ready_o = ready_q;
  assign out_valid_o  = out_v_q;
  assign op_class_o   = out_q.op_class;
  assign rd_o         = out_q.rd;
  assign rs1_o        = out_q.rs1;
  assign rs2_o        = out_q.rs2;
  assign funct3_o     = out_q.funct3;
  assign funct7b5_o   = out_q.funct7b5;
  assign imm_o        = out_q.imm;
  assign pc_o         = out_q.pc;
  assign illegal_o    = out_q.illegal;

endmodule
